vga_text_renderer: RTL and testbench
====================================

# vga_text_renderer

Scan-out engine for the 80x30 text console. It generates 640x480@60 VGA timing from the pixel clock and reads the text buffer at `{row, col}` addresses, the same layout the terminal writer stores characters in. It looks up each character in an 8x16 font ROM and drives a 1-bit pixel stream with sync, data-enable and a blinking cursor. It sits between the dual-port text RAM read port and the VGA DAC pins.

## Interface
Parameters:
- `H_ACTIVE`, 640: visible pixels per line
- `H_FP`, 16: horizontal front porch
- `H_SYNC`, 96: horizontal sync width
- `H_BP`, 48: horizontal back porch
- `V_ACTIVE`, 480: visible lines per frame
- `V_FP`, 10: vertical front porch
- `V_SYNC`, 2: vertical sync width
- `V_BP`, 33: vertical back porch
- `BLINK_FRAMES`, 32: frames per cursor blink phase

Ports (one clock; reset is asynchronous and active-low):
- `i_clk`  in  1  pixel clock, 25.175 MHz
- `i_rst_n`  in  1  asynchronous active-low reset
- `o_address`  out  13  text RAM read address `{row[4:0], col[6:0]}`
- `i_data`  in  8  text RAM read data; synchronous RAM, valid 1 cycle after `o_address`
- `o_font_addr`  out  12  font ROM address `{char[7:0], line[3:0]}`
- `i_font_data`  in  8  font ROM data; valid 1 cycle after `o_font_addr`; MSB is the leftmost pixel
- `i_cursor_en`  in  1  cursor display enable
- `i_cursor_row`  in  5  cursor row
- `i_cursor_col`  in  7  cursor column
- `o_pixel`  out  1  pixel value, forced to 0 outside the active area
- `o_de`  out  1  active-video flag
- `o_hsync`  out  1  horizontal sync, active low
- `o_vsync`  out  1  vertical sync, active low
- `o_frame_start`  out  1  one-cycle pulse aligned with the first active pixel of a frame

## Operation
- `hcnt` counts 0..799 and wraps to 0. `vcnt` increments when `hcnt` wraps and counts 0..524, then wraps to 0.
- Active area: `hcnt < 640` and `vcnt < 480`.
- Sync low when `hcnt` is in 656..751, or when `vcnt` is in 490..491.
- Text cell: `col = hcnt[9:3]`, `row = vcnt[8:4]`, `line = vcnt[3:0]`, `bit = hcnt[2:0]`.
- Stage 1 registers `o_address = {row, col}` when active, otherwise 0. The same address is re-issued for all 8 pixels of a cell.
- Stage 3 registers `o_font_addr = {i_data, line_d2}`.
- Stage 5 registers `o_pixel = de_d4 & (i_font_data[7 - bit_d4] ^ cur_d4)`.
- `cur` = `i_cursor_en` & `blink` & (`row == i_cursor_row`) & (`col == i_cursor_col`). The cursor is a full-cell inverse. Cursor inputs are sampled at stage 0.
- Blink: a frame counter increments when `hcnt == 0` and `vcnt == 0`. When it reaches `BLINK_FRAMES - 1` it clears and toggles `blink`.
- A cursor row or column out of range (row > 29 or col > 79) never matches, so no cursor is shown.

## Timing
- Fixed latency of 5 cycles from counter value to `o_pixel`. `o_de`, `o_hsync`, `o_vsync` and `o_frame_start` are delayed 5 cycles to match, so all outputs are mutually aligned.
- All outputs are registered. Frame period is 800 × 525 = 420000 cycles.
- Reset values: `hcnt`, `vcnt`, frame counter and `blink` are 0. `o_address`, `o_font_addr`, `o_pixel`, `o_de` and `o_frame_start` are 0. `o_hsync` and `o_vsync` are 1. All delay-line stages hold their inactive values.
- Reset asserted mid-line: all state returns to reset values immediately. After deassertion, the first `o_de` rises 5 cycles after the first clock edge, with `o_frame_start` on the same cycle.
- No stall or handshake: RAM and ROM must return data in exactly 1 cycle. Text writes on the other RAM port may tear within a frame; this is accepted.

## Structure
- Package `vga_text_pkg`: timing defaults, `TEXT_COLS = 80`, `TEXT_ROWS = 30`, `FONT_W = 8`, `FONT_H = 16`, `PIPE_LAT = 5`, and the address widths (13 and 12).
- Sub-module `vga_timing` contains the h/v counters, raw sync, active flag and frame-start signal. The renderer adds the fetch pipeline, delay lines and cursor logic.

## Test plan
- Reset: hold `i_rst_n = 0`, toggle the clock. Expect `o_hsync = o_vsync = 1`, `o_de = o_pixel = 0`, `o_address = 0`.
- Pixel fetch: RAM model returns 0x41 everywhere, ROM returns 0x81 for all lines. On line 0, `o_pixel` repeats 1,0,0,0,0,0,0,1 per cell, starting 5 cycles after release, for 640 cycles; then 0.
- Addressing: at `vcnt = 16`, `hcnt = 8`, expect `o_address = 0x081` one cycle later. At `vcnt = 479`, `hcnt = 639`, expect `o_address = {29, 79}`.
- Sync: `o_hsync` is low for exactly 96 cycles starting 661 cycles after line start. `o_vsync` is low for exactly 1600 cycles per frame. `o_frame_start` pulses once every 420000 cycles.
- Cursor: set `i_cursor_en = 1`, row 2, col 3, ROM returns 0x00. Cell (2,3) shows all pixels 1 during blink-on frames, all 0 for 32 frames after that, and so on. Setting col = 80 shows no cursor.
- Reset mid-frame: assert `i_rst_n` at `vcnt = 200`. Outputs return to reset values asynchronously. After release, timing restarts from `hcnt = vcnt = 0`.

Source files
------------

// File: rtl/vga_text_pkg.sv
// Shared constants for the 80x30 text console scan-out, plus the control word
// that travels down the fetch pipeline beside each pixel.
package vga_text_pkg;
    localparam int H_ACTIVE_DEF = 640;
    localparam int H_FP_DEF     = 16;
    localparam int H_SYNC_DEF   = 96;
    localparam int H_BP_DEF     = 48;
    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FP_DEF     = 10;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BP_DEF     = 33;

    localparam int TEXT_COLS   = 80;
    localparam int TEXT_ROWS   = 30;
    localparam int FONT_W      = 8;
    localparam int FONT_H      = 16;
    localparam int PIPE_LAT    = 5;
    localparam int ADDR_W      = 13;
    localparam int FONT_ADDR_W = 12;
    localparam int CNT_W       = 10;

    typedef struct packed {
        logic       de;
        logic       hs_n;
        logic       vs_n;
        logic       fs;
        logic       cur;
        logic [2:0] bit_idx;
    } ctl_t;

    localparam ctl_t CTL_IDLE = '{de: 1'b0, hs_n: 1'b1, vs_n: 1'b1, fs: 1'b0,
                                  cur: 1'b0, bit_idx: 3'd0};
endpackage

// File: rtl/vga_timing.sv
// Horizontal/vertical raster counters with raw (undelayed) sync, active and
// frame-start flags derived combinationally from the counter values.
module vga_timing
    import vga_text_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int H_FP     = H_FP_DEF,
    parameter int H_SYNC   = H_SYNC_DEF,
    parameter int H_BP     = H_BP_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int V_FP     = V_FP_DEF,
    parameter int V_SYNC   = V_SYNC_DEF,
    parameter int V_BP     = V_BP_DEF
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    output logic [CNT_W-1:0] o_hcnt,
    output logic [CNT_W-1:0] o_vcnt,
    output logic             o_active,
    output logic             o_hsync_n,
    output logic             o_vsync_n,
    output logic             o_frame_start
);
    localparam int H_TOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL   = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int H_SYNC_LO = H_ACTIVE + H_FP;
    localparam int H_SYNC_HI = H_SYNC_LO + H_SYNC;
    localparam int V_SYNC_LO = V_ACTIVE + V_FP;
    localparam int V_SYNC_HI = V_SYNC_LO + V_SYNC;

    logic [CNT_W-1:0] r_hcnt;
    logic [CNT_W-1:0] r_vcnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_hcnt <= '0;
            r_vcnt <= '0;
        end else if (r_hcnt == CNT_W'(H_TOTAL - 1)) begin
            r_hcnt <= '0;
            r_vcnt <= (r_vcnt == CNT_W'(V_TOTAL - 1)) ? '0 : r_vcnt + 1'b1;
        end else begin
            r_hcnt <= r_hcnt + 1'b1;
        end
    end

    assign o_hcnt        = r_hcnt;
    assign o_vcnt        = r_vcnt;
    assign o_active      = (r_hcnt < CNT_W'(H_ACTIVE)) && (r_vcnt < CNT_W'(V_ACTIVE));
    assign o_hsync_n     = !((r_hcnt >= CNT_W'(H_SYNC_LO)) && (r_hcnt < CNT_W'(H_SYNC_HI)));
    assign o_vsync_n     = !((r_vcnt >= CNT_W'(V_SYNC_LO)) && (r_vcnt < CNT_W'(V_SYNC_HI)));
    assign o_frame_start = (r_hcnt == '0) && (r_vcnt == '0);
endmodule

// File: rtl/vga_text_renderer.sv
// Text-mode scan-out: raster timing, text RAM and font ROM fetch, cursor
// overlay, with every output delayed to line up with the pixel (5 cycles).
module vga_text_renderer
    import vga_text_pkg::*;
#(
    parameter int H_ACTIVE     = H_ACTIVE_DEF,
    parameter int H_FP         = H_FP_DEF,
    parameter int H_SYNC       = H_SYNC_DEF,
    parameter int H_BP         = H_BP_DEF,
    parameter int V_ACTIVE     = V_ACTIVE_DEF,
    parameter int V_FP         = V_FP_DEF,
    parameter int V_SYNC       = V_SYNC_DEF,
    parameter int V_BP         = V_BP_DEF,
    parameter int BLINK_FRAMES = 32
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    output logic [ADDR_W-1:0]      o_address,
    input  logic [7:0]             i_data,
    output logic [FONT_ADDR_W-1:0] o_font_addr,
    input  logic [7:0]             i_font_data,
    input  logic                   i_cursor_en,
    input  logic [4:0]             i_cursor_row,
    input  logic [6:0]             i_cursor_col,
    output logic                   o_pixel,
    output logic                   o_de,
    output logic                   o_hsync,
    output logic                   o_vsync,
    output logic                   o_frame_start
);
    localparam int COLS    = H_ACTIVE / FONT_W;
    localparam int ROWS    = V_ACTIVE / FONT_H;
    localparam int FRAME_W = $clog2(BLINK_FRAMES + 1);

    logic [CNT_W-1:0] w_hcnt;
    logic [CNT_W-1:0] w_vcnt;
    logic             w_active;
    logic             w_hs_n;
    logic             w_vs_n;
    logic             w_fs;
    logic [6:0]       w_col;
    logic [4:0]       w_row;
    logic [3:0]       w_line;
    logic             w_cur;
    ctl_t             w_ctl_p0;

    logic [FRAME_W-1:0] r_frame;
    logic               r_blink;
    ctl_t               r_ctl_p1, r_ctl_p2, r_ctl_p3, r_ctl_p4;
    logic [3:0]         r_line_p1, r_line_p2;

    vga_timing #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
    ) u_timing (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .o_hcnt        (w_hcnt),
        .o_vcnt        (w_vcnt),
        .o_active      (w_active),
        .o_hsync_n     (w_hs_n),
        .o_vsync_n     (w_vs_n),
        .o_frame_start (w_fs)
    );

    assign w_col  = 7'(w_hcnt >> 3);
    assign w_row  = 5'(w_vcnt >> 4);
    assign w_line = w_vcnt[3:0];

    // Out-of-range cursor coordinates are rejected explicitly so they never
    // alias onto blanking-interval cells.
    assign w_cur = i_cursor_en && r_blink
                && (w_row == i_cursor_row) && (w_col == i_cursor_col)
                && (i_cursor_row < 5'(ROWS)) && (i_cursor_col < 7'(COLS));

    always_comb begin
        w_ctl_p0         = CTL_IDLE;
        w_ctl_p0.de      = w_active;
        w_ctl_p0.hs_n    = w_hs_n;
        w_ctl_p0.vs_n    = w_vs_n;
        w_ctl_p0.fs      = w_fs;
        w_ctl_p0.cur     = w_cur;
        w_ctl_p0.bit_idx = w_hcnt[2:0];
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_frame <= '0;
            r_blink <= 1'b0;
        end else if (w_fs) begin
            if (r_frame == FRAME_W'(BLINK_FRAMES - 1)) begin
                r_frame <= '0;
                r_blink <= !r_blink;
            end else begin
                r_frame <= r_frame + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ctl_p1      <= CTL_IDLE;
            r_ctl_p2      <= CTL_IDLE;
            r_ctl_p3      <= CTL_IDLE;
            r_ctl_p4      <= CTL_IDLE;
            r_line_p1     <= '0;
            r_line_p2     <= '0;
            o_address     <= '0;
            o_font_addr   <= '0;
            o_pixel       <= 1'b0;
            o_de          <= 1'b0;
            o_hsync       <= 1'b1;
            o_vsync       <= 1'b1;
            o_frame_start <= 1'b0;
        end else begin
            // p0 -> p1: issue text RAM address
            r_ctl_p1  <= w_ctl_p0;
            r_line_p1 <= w_line;
            o_address <= w_active ? {1'b0, w_row, w_col} : '0;
            // p2 -> p3: character code arrives, issue font ROM address
            r_ctl_p2    <= r_ctl_p1;
            r_line_p2   <= r_line_p1;
            r_ctl_p3    <= r_ctl_p2;
            o_font_addr <= {i_data, r_line_p2};
            // p4 -> p5: glyph row arrives, select bit and apply cursor inverse
            r_ctl_p4      <= r_ctl_p3;
            o_pixel       <= r_ctl_p4.de & (i_font_data[3'd7 - r_ctl_p4.bit_idx] ^ r_ctl_p4.cur);
            o_de          <= r_ctl_p4.de;
            o_hsync       <= r_ctl_p4.hs_n;
            o_vsync       <= r_ctl_p4.vs_n;
            o_frame_start <= r_ctl_p4.fs;
        end
    end
endmodule

// File: tb/tb_vga_text_renderer.sv
// Bench for vga_text_renderer on a shrunken raster (112x39, blink every 2 frames)
// so several frames fit in a short run; a raster model is checked every cycle.
module tb_vga_text_renderer;
    localparam int HA = 80, HF = 8, HS = 16, HB = 8;
    localparam int VA = 32, VF = 2, VS = 2, VB = 3;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FT = HT * VT;
    localparam int BF = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [12:0] addr;
    logic [7:0]  ram_q = 8'h00;
    logic [11:0] faddr;
    logic [7:0]  rom_q = 8'h00;
    logic        cen = 1'b0;
    logic [4:0]  crow = 5'd0;
    logic [6:0]  ccol = 7'd0;
    logic        pix, de, hs, vs, fs;

    int mode = 0;
    int ncyc = 0;
    int nvec = 0;
    int nerr = 0;

    vga_text_renderer #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .BLINK_FRAMES(BF)
    ) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .o_address     (addr),
        .i_data        (ram_q),
        .o_font_addr   (faddr),
        .i_font_data   (rom_q),
        .i_cursor_en   (cen),
        .i_cursor_row  (crow),
        .i_cursor_col  (ccol),
        .o_pixel       (pix),
        .o_de          (de),
        .o_hsync       (hs),
        .o_vsync       (vs),
        .o_frame_start (fs)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] ram_char(input logic [12:0] a);
        if (mode == 0) return 8'h41;
        return 8'(int'(a) * 37 + 11);
    endfunction

    function automatic logic [7:0] rom_byte(input logic [11:0] fa);
        if (mode == 0) return 8'h81;
        if (fa[3:0] == 4'd0) return 8'h00;
        return 8'(int'(fa) * 29 + 7) ^ 8'(fa >> 4);
    endfunction

    always @(posedge clk) begin
        ram_q <= ram_char(addr);
        rom_q <= rom_byte(faddr);
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) ncyc <= 0;
        else        ncyc <= ncyc + 1;
    end

    // Raster model: position p counts pixel clocks since reset release.
    function automatic bit m_active(input int p);
        int h, v;
        h = p % HT;
        v = (p / HT) % VT;
        return (h < HA) && (v < VA);
    endfunction

    function automatic logic [12:0] m_addr(input int p);
        int h, v;
        h = p % HT;
        v = (p / HT) % VT;
        if (!m_active(p)) return 13'd0;
        return (v / 16) * 128 + (h / 8);
    endfunction

    function automatic logic [3:0] m_line(input int p);
        return 4'(((p / HT) % VT) % 16);
    endfunction

    function automatic bit m_pixel(input int p);
        int h, v, k;
        logic [7:0] fb;
        bit cur;
        h = p % HT;
        v = (p / HT) % VT;
        k = p / FT;
        if (!m_active(p)) return 1'b0;
        fb  = rom_byte({ram_char(m_addr(p)), m_line(p)});
        cur = cen && ((((k + 1) / BF) % 2) == 1)
              && (v / 16 == int'(crow)) && (h / 8 == int'(ccol))
              && (int'(crow) < VA / 16) && (int'(ccol) < HA / 8);
        return fb[7 - (h % 8)] ^ cur;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, ncyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        int n, p;
        if (rst_n && ncyc >= 1) begin
            n = ncyc;
            p = n - 5;
            chk("address", 32'(addr), 32'(m_addr(n - 1)));
            if (n >= 3) chk("font_addr", 32'(faddr), 32'({ram_char(m_addr(n - 3)), m_line(n - 3)}));
            if (p < 0) begin
                chk("de", 32'(de), 32'd0);
                chk("pixel", 32'(pix), 32'd0);
                chk("hsync", 32'(hs), 32'd1);
                chk("vsync", 32'(vs), 32'd1);
                chk("frame_start", 32'(fs), 32'd0);
            end else begin
                chk("de", 32'(de), 32'(m_active(p)));
                chk("pixel", 32'(pix), 32'(m_pixel(p)));
                chk("hsync", 32'(hs), 32'(!((p % HT) >= HA + HF && (p % HT) < HA + HF + HS)));
                chk("vsync", 32'(vs), 32'(!(((p / HT) % VT) >= VA + VF && ((p / HT) % VT) < VA + VF + VS)));
                chk("frame_start", 32'(fs), 32'((p % FT) == 0));
            end
        end
    end

    task automatic wait_cyc(input int n);
        int g = 0;
        while (ncyc < n && g < 200000) begin
            @(negedge clk);
            g++;
        end
        chk("wait_cycle", 32'(ncyc), 32'(n));
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_hsync"}, 32'(hs), 32'd1);
        chk({tag, "_vsync"}, 32'(vs), 32'd1);
        chk({tag, "_de"}, 32'(de), 32'd0);
        chk({tag, "_pixel"}, 32'(pix), 32'd0);
        chk({tag, "_address"}, 32'(addr), 32'd0);
        chk({tag, "_font_addr"}, 32'(faddr), 32'd0);
        chk({tag, "_frame_start"}, 32'(fs), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [7:0] pat;
        int p0;
        pat = 8'b1000_0001;

        repeat (3) @(negedge clk);
        chk_reset_vals("reset");
        rst_n = 1'b1;

        // Phase A: every cell is 'A' (0x41), every glyph row is 0x81.
        wait_cyc(3);
        chk("A_font_addr_first", 32'(faddr), 32'h410);
        for (int i = 0; i < 8; i++) begin
            wait_cyc(5 + i);
            chk("A_line0_pixel", 32'(pix), 32'(pat[7 - i]));
        end
        wait_cyc(85);
        chk("A_blank_pixel", 32'(pix), 32'd0);
        chk("A_blank_de", 32'(de), 32'd0);
        wait_cyc(92);
        chk("A_hsync_before", 32'(hs), 32'd1);
        wait_cyc(93);
        chk("A_hsync_first_low", 32'(hs), 32'd0);
        wait_cyc(108);
        chk("A_hsync_last_low", 32'(hs), 32'd0);
        wait_cyc(109);
        chk("A_hsync_after", 32'(hs), 32'd1);
        wait_cyc(16 * HT + 8 + 1);
        chk("A_address_r1c1", 32'(addr), 32'h081);
        wait_cyc(FT + 5);
        chk("A_frame_start_2nd", 32'(fs), 32'd1);

        // Mid-line, mid-frame asynchronous reset (line 20, pixel 37 of frame 1).
        wait_cyc(FT + 20 * HT + 37);
        chk("A_pre_reset_de", 32'(de), 32'd1);
        chk("A_pre_reset_address", 32'(addr), 32'h084);
        #2 rst_n = 1'b0;
        #1 chk_reset_vals("async_reset");
        repeat (2) @(negedge clk);
        chk_reset_vals("held_reset");

        // Phase B: varied text and glyphs, cursor on cell (1,3); line 0 glyphs are blank.
        mode = 1;
        cen  = 1'b1;
        crow = 5'd1;
        ccol = 7'd3;
        @(negedge clk);
        rst_n = 1'b1;
        wait_cyc(4);
        chk("B_de_before_first", 32'(de), 32'd0);
        wait_cyc(5);
        chk("B_de_first", 32'(de), 32'd1);
        chk("B_frame_start_first", 32'(fs), 32'd1);

        for (int k = 0; k < 6; k++) begin
            p0 = k * FT + 16 * HT + 24;
            wait_cyc(p0 + 5);
            chk("B_cursor_left", 32'(pix), 32'(k == 1 || k == 2 || k == 5));
            wait_cyc(p0 + 12);
            chk("B_cursor_right", 32'(pix), 32'(k == 1 || k == 2 || k == 5));
            wait_cyc(p0 + 13);
            chk("B_next_cell", 32'(pix), 32'd0);
        end

        // Move the cursor out of range during vertical blanking.
        wait_cyc(5 * FT + 34 * HT);
        ccol = 7'd80;
        p0 = 6 * FT + 16 * HT + 24;
        wait_cyc(p0 + 5);
        chk("B_cursor_col80", 32'(pix), 32'd0);
        wait_cyc(7 * FT + 10);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
